// File: rtl/led_pkg.sv
// Shared definitions for the LED brightness engine: channel modes, breathe
// states and small width helpers.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } br_state_e;

    // Width that holds (level+1)^2 without overflow.
    function automatic int sq_width(input int pwm_bits);
        return 2 * pwm_bits + 2;
    endfunction

    // Counter width for a 0..n-1 range; never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_breathe_ch.sv
// One LED channel: mode decode, breathe ramp FSM, blink bit, duty curve and
// the registered LED / cycle_done outputs. Timing comes from the shared timebase.
module led_breathe_ch
    import led_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int HOLD_STEPS = 8,
    parameter int GAMMA      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic [1:0]          i_mode,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_step_tick,
    output logic                o_led,
    output logic                o_cycle_done
);

    localparam int SQ_W   = sq_width(PWM_BITS);
    localparam int HOLD_W = cnt_width(HOLD_STEPS);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
    localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
    localparam logic [SQ_W-1:0]     SQ_ONE    = SQ_W'(1);

    mode_e                r_mode_prev;
    br_state_e            r_state,    w_state_nxt;
    logic [PWM_BITS-1:0]  r_level,    w_level_nxt;
    logic [HOLD_W-1:0]    r_hold_cnt, w_hold_nxt;
    logic                 r_blink,    w_blink_nxt;
    logic                 r_led,      w_led_nxt;
    logic                 r_cycle_done, w_done_nxt;

    mode_e                w_mode;
    logic                 w_enter_br;
    logic                 w_enter_bl;
    logic [PWM_BITS-1:0]  w_level_eff;
    logic [SQ_W-1:0]      w_lp1;
    logic [SQ_W-1:0]      w_sq;
    logic [PWM_BITS-1:0]  w_duty;

    assign w_mode     = mode_e'(i_mode);
    assign w_enter_br = (w_mode == MODE_BREATHE) && (r_mode_prev != MODE_BREATHE);
    assign w_enter_bl = (w_mode == MODE_BLINK)   && (r_mode_prev != MODE_BLINK);

    // On the entry cycle the level is already considered 0, so the PWM compare uses that.
    assign w_level_eff = w_enter_br ? '0 : r_level;
    assign w_lp1       = SQ_W'(w_level_eff) + SQ_ONE;
    assign w_sq        = w_lp1 * w_lp1 - SQ_ONE;
    assign w_duty      = (GAMMA != 0) ? PWM_BITS'(w_sq >> PWM_BITS) : w_level_eff;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_mode_prev  <= MODE_OFF;
            r_state      <= RISE;
            r_level      <= '0;
            r_hold_cnt   <= '0;
            r_blink      <= 1'b1;
            r_led        <= 1'b0;
            r_cycle_done <= 1'b0;
        end else if (i_en) begin
            r_mode_prev  <= w_mode;
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_blink      <= w_blink_nxt;
            r_led        <= w_led_nxt;
            r_cycle_done <= w_done_nxt;
        end else begin
            r_led        <= 1'b0;
            r_cycle_done <= 1'b0;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_hold_nxt  = r_hold_cnt;
        w_blink_nxt = r_blink;
        w_done_nxt  = 1'b0;
        w_led_nxt   = 1'b0;

        if (w_enter_br) begin
            w_state_nxt = RISE;
            w_level_nxt = '0;
            w_hold_nxt  = '0;
        end else if (w_mode == MODE_BREATHE && i_step_tick) begin
            unique case (r_state)
                RISE: begin
                    w_level_nxt = r_level + LVL_ONE;
                    if (r_level + LVL_ONE == LVL_MAX)
                        w_state_nxt = (HOLD_STEPS == 0) ? FALL : HOLD_HI;
                end
                HOLD_HI: begin
                    w_hold_nxt = r_hold_cnt + HOLD_ONE;
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = FALL;
                    end
                end
                FALL: begin
                    w_level_nxt = r_level - LVL_ONE;
                    if (r_level == LVL_ONE) begin
                        w_state_nxt = (HOLD_STEPS == 0) ? RISE : HOLD_LO;
                        w_done_nxt  = (HOLD_STEPS == 0);
                    end
                end
                HOLD_LO: begin
                    w_hold_nxt = r_hold_cnt + HOLD_ONE;
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = RISE;
                        w_done_nxt  = 1'b1;
                    end
                end
            endcase
        end

        if (w_enter_bl)
            w_blink_nxt = 1'b1;
        else if (w_mode == MODE_BLINK && i_step_tick)
            w_blink_nxt = ~r_blink;

        unique case (w_mode)
            MODE_OFF:     w_led_nxt = 1'b0;
            MODE_ON:      w_led_nxt = 1'b1;
            MODE_BLINK:   w_led_nxt = w_enter_bl ? 1'b1 : r_blink;
            MODE_BREATHE: w_led_nxt = (i_pwm_cnt < w_duty);
        endcase
    end

    assign o_led        = r_led;
    assign o_cycle_done = r_cycle_done;

endmodule

// File: rtl/led_breathe_pwm.sv
// Multi-channel LED brightness engine: one shared prescaler / PWM / step
// timebase feeding N_CH independent off/on/blink/breathe channels.
module led_breathe_pwm
    import led_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int PWM_BITS     = 8,
    parameter int PRE_DIV      = 4,
    parameter int STEP_PERIODS = 16,
    parameter int HOLD_STEPS   = 8,
    parameter int GAMMA        = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2*N_CH-1:0] mode,
    output logic [N_CH-1:0]   led,
    output logic [N_CH-1:0]   cycle_done
);

    localparam int PRE_W  = cnt_width(PRE_DIV);
    localparam int STEP_W = cnt_width(STEP_PERIODS);
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRE_DIV - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

    logic [PRE_W-1:0]    r_pre_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [STEP_W-1:0]   r_step_cnt;
    logic                w_pwm_tick;
    logic                w_period_end;
    logic                w_step_tick;

    assign w_pwm_tick   = (r_pre_cnt == PRE_LAST);
    assign w_period_end = w_pwm_tick && (r_pwm_cnt == PWM_MAX);
    assign w_step_tick  = en && w_period_end && (r_step_cnt == STEP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt  <= '0;
            r_pwm_cnt  <= '0;
            r_step_cnt <= '0;
        end else if (en) begin
            r_pre_cnt <= w_pwm_tick ? '0 : r_pre_cnt + PRE_ONE;
            if (w_pwm_tick)
                r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
            if (w_period_end)
                r_step_cnt <= (r_step_cnt == STEP_LAST) ? '0 : r_step_cnt + STEP_ONE;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        led_breathe_ch #(
            .PWM_BITS   (PWM_BITS),
            .HOLD_STEPS (HOLD_STEPS),
            .GAMMA      (GAMMA)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_en         (en),
            .i_mode       (mode[2*gi +: 2]),
            .i_pwm_cnt    (r_pwm_cnt),
            .i_step_tick  (w_step_tick),
            .o_led        (led[gi]),
            .o_cycle_done (cycle_done[gi])
        );
    end

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Scoreboard bench: three engines (linear/hold 2, gamma, hold 0) on an 8-clk
// PWM period; expected outputs come from the documented level sequences.
module tb_led_breathe_pwm;

    typedef struct packed {
        logic [3:0] led_m, done_m, led_g, done_g, led_h, done_h;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, en_on;
    logic [7:0] mode_m, mode_g, mode_h;
    logic [3:0] led_m, done_m, led_g, done_g, led_h, done_h;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_edge   = 0;   // non-reset edges since release
    int         n_main   = 0;   // enabled edges of the main engine
    int         n_h      = 0;   // edges since ch1 of the hold-0 engine (re)started
    logic [1:0] h_prev   = 2'd0;

    always #5 clk = ~clk;

    led_breathe_pwm #(.N_CH(4), .PWM_BITS(3), .PRE_DIV(1), .STEP_PERIODS(1), .HOLD_STEPS(2), .GAMMA(0))
    u_dut (.clk(clk), .rst(rst), .en(en), .mode(mode_m), .led(led_m), .cycle_done(done_m));

    led_breathe_pwm #(.N_CH(4), .PWM_BITS(3), .PRE_DIV(1), .STEP_PERIODS(1), .HOLD_STEPS(2), .GAMMA(1))
    u_dut_g (.clk(clk), .rst(rst), .en(en_on), .mode(mode_g), .led(led_g), .cycle_done(done_g));

    led_breathe_pwm #(.N_CH(4), .PWM_BITS(3), .PRE_DIV(1), .STEP_PERIODS(1), .HOLD_STEPS(0), .GAMMA(0))
    u_dut_h (.clk(clk), .rst(rst), .en(en_on), .mode(mode_h), .led(led_h), .cycle_done(done_h));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // Level per step period: 0,1..7,7,7,6..1,0,0 (hold 2) or 0..7,6..1 (hold 0).
    function automatic int level_of(input int p, input bit hold2);
        int q;
        if (hold2) begin
            q = p % 18;
            if (q <= 7)  return q;
            if (q <= 9)  return 7;
            if (q <= 15) return 16 - q;
            return 0;
        end
        q = p % 14;
        return (q <= 7) ? q : 14 - q;
    endfunction

    function automatic int gamma_duty(input int lvl);
        int tbl [8] = '{0, 0, 1, 1, 3, 4, 6, 7};
        return tbl[lvl];
    endfunction

    // Expected channel outputs after the n-th counted edge of its timeline.
    task automatic ch_exp(input logic [1:0] md, input int n, input bit hold2, input bit gam,
                          output logic l, output logic d);
        int m, lvl, duty;
        l = 1'b0;
        d = 1'b0;
        case (md)
            2'd1: l = 1'b1;
            2'd2: l = (n == 0) ? 1'b1 : (((n - 1) / 8) % 2 == 0);
            2'd3: if (n > 0) begin
                m    = n - 1;
                lvl  = level_of(m / 8, hold2);
                duty = gam ? gamma_duty(lvl) : lvl;
                l    = ((m % 8) < duty);
                d    = (n % (hold2 ? 144 : 112)) == 0;
            end
            default: ;
        endcase
    endtask

    task automatic step();
        exp_t e;
        exp_t got;
        logic l, d;
        e = '0;
        if (rst) begin
            n_edge = 0;
            n_main = 0;
            n_h    = 0;
            h_prev = 2'd0;
        end else begin
            n_edge++;
            if (en) begin
                n_main++;
                for (int c = 0; c < 4; c++) begin
                    ch_exp(mode_m[2*c +: 2], n_main, 1'b1, 1'b0, l, d);
                    e.led_m[c]  = l;
                    e.done_m[c] = d;
                end
            end
            for (int c = 0; c < 4; c++) begin
                ch_exp(mode_g[2*c +: 2], n_edge, 1'b1, 1'b1, l, d);
                e.led_g[c]  = l;
                e.done_g[c] = d;
            end
            // Re-entry is placed on a PWM wrap, so the new ramp is phase-aligned with a fresh period.
            if (n_edge > 1 && mode_h[3:2] == 2'd3 && h_prev != 2'd3) n_h = 0;
            else n_h++;
            h_prev = mode_h[3:2];
            for (int c = 0; c < 4; c++) begin
                ch_exp(mode_h[2*c +: 2], n_h, 1'b0, 1'b0, l, d);
                e.led_h[c]  = l;
                e.done_h[c] = d;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("led_main",  led_m,  got.led_m);
        check("done_main", done_m, got.done_m);
        check("led_gamma", led_g,  got.led_g);
        check("done_gamma", done_g, got.done_g);
        check("led_hold0", led_h,  got.led_h);
        check("done_hold0", done_h, got.done_h);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        en_on  = 1'b1;
        mode_m = 8'b00_01_00_01;
        mode_g = 8'b0;
        mode_h = 8'b0;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;
        repeat (12) step();

        rst    = 1'b1;
        mode_m = 8'b01_10_00_11;
        mode_g = 8'b00_00_00_11;
        mode_h = 8'b00_00_11_00;
        repeat (3) step();
        rst = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (k == 36) en = 1'b0;
            if (k == 86) en = 1'b1;
            if (k == 80) mode_h = 8'b0;
            if (k == 87) mode_h = 8'b00_00_11_00;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_breathe_pwm.md
Name: led_breathe_pwm

Overview:
Multi-channel LED brightness engine that generalises the fixed weak-strong-weak pattern generator. It drives N_CH independent LED outputs from one shared prescaler, PWM counter and step timebase. Each channel runs in one of four modes: off, on, blink or breathe. Breathe is a parametrised triangle ramp with hold plateaus and an optional square-law (gamma) brightness curve. The block sits between board-level LED pins and the mode-select bits from control logic.

Parameters:
N_CH, 4, number of LED channels
PWM_BITS, 8, PWM resolution; PWM period is 2^PWM_BITS pwm ticks; MAX_LEVEL = 2^PWM_BITS-1
PRE_DIV, 4, clk cycles per pwm tick (>=1)
STEP_PERIODS, 16, PWM periods per brightness step tick (>=1)
HOLD_STEPS, 8, step ticks spent at top and at bottom plateau (0 = no plateau)
GAMMA, 0, 0 = linear duty; 1 = square-law duty

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  global enable; low freezes all timing and forces led low
mode  in  2*N_CH  per-channel mode, channel i at bits [2i+1:2i]
led  out  N_CH  registered LED drive
cycle_done  out  N_CH  one-cycle pulse when a breathe channel completes a full cycle

Behaviour:
- Reset: led=0, cycle_done=0, all counters=0, every level=0, every FSM=RISE, blink bits=1.
- Reset takes priority over en and mode.
- Prescaler: pre_cnt runs 0..PRE_DIV-1. pwm_tick is asserted when pre_cnt==PRE_DIV-1.
- PWM counter: pwm_cnt (PWM_BITS wide) increments on pwm_tick and wraps MAX_LEVEL->0.
- period_end = pwm_tick && pwm_cnt==MAX_LEVEL.
- Step counter: counts period_end, range 0..STEP_PERIODS-1. step_tick is asserted on the period_end that takes it to its last value, and the counter then wraps.
- en=0: prescaler, PWM, step and hold counters plus all channel state hold their values. led=0 and cycle_done=0 on the next edge. On en=1 everything resumes from the held values.
- Mode decode (shared package): 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
- Mode changes are sampled every cycle.
- Entering BREATHE from any other mode sets level=0, FSM=RISE, hold_cnt=0.
- Entering BLINK sets blink=1.
- Breathe FSM per channel; all transitions occur only on step_tick:
  - RISE: level++. If level+1==MAX_LEVEL, go to HOLD_HI, or to FALL if HOLD_STEPS==0.
  - HOLD_HI: hold_cnt++. At hold_cnt==HOLD_STEPS-1, clear hold_cnt and go to FALL.
  - FALL: level--. If level-1==0, go to HOLD_LO, or to RISE with a cycle_done pulse if HOLD_STEPS==0.
  - HOLD_LO: as HOLD_HI, then go to RISE and pulse cycle_done for exactly one clk.
- Full cycle length = 2*MAX_LEVEL + 2*HOLD_STEPS step ticks.
- Duty:
  - GAMMA=0: duty=level.
  - GAMMA=1: duty=((level+1)^2-1)>>PWM_BITS, computed at 2*PWM_BITS+2 width. level 0 gives 0; MAX gives MAX.
- Output, registered with 1-cycle latency from pwm_cnt/state:
  - OFF: led=0.
  - ON: led=1.
  - BLINK: led=blink; blink toggles on each step_tick.
  - BREATHE: led=(pwm_cnt < duty). Max duty is MAX_LEVEL/2^PWM_BITS, so the LED is never solid on in breathe.
- cycle_done is asserted only in BREATHE mode; it is 0 in all other modes.
- Simultaneous mode change and step_tick: the mode-entry init wins; the step is not applied.
- Channels are fully independent except for the shared timebase.

Decomposition:
- Shared package led_pkg holds:
  - mode encodings MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE;
  - breathe state typedef (RISE, HOLD_HI, FALL, HOLD_LO);
  - the duty width helper.
- One sub-module, led_breathe_ch, holds the per-channel FSM, level, hold counter, blink bit, duty computation and output register.
- The top module contains the shared prescaler, PWM and step counters, plus a generate loop of N_CH led_breathe_ch instances.

Test Plan:
All scenarios use PRE_DIV=1, PWM_BITS=3, STEP_PERIODS=1, HOLD_STEPS=2 unless stated.
1. Reset and static modes: rst for 3 cycles, then mode=ON,OFF,ON,OFF -> during rst led=0000; one cycle after release led=0101, held constant.
2. Breathe timing: ch0 BREATHE from reset -> cycle_done[0] pulses once every 144 clk (18 steps x 8). Level sequence per 8-cycle period is 0,1..7,7,7,6..1,0,0; led high count per period equals level.
3. Gamma: GAMMA=1, observe period with level=3 -> led high 1 of 8 cycles (linear gives 3). level=7 -> 7 of 8; level=0 -> 0.
4. Blink: ch2 BLINK -> led[2]=1 for 8 clk, then 0 for 8, alternating; cycle_done[2] stays 0.
5. en freeze: ch0 BREATHE at level 4 rising, drop en for 50 clk -> led=0 throughout and no cycle_done. After en=1 the PWM phase and level continue from the held values, and the next cycle_done arrives 50 clk later than it would have without the freeze.
6. Mode re-entry plus HOLD_STEPS=0: ch1 BREATHE mid-FALL, switch to OFF then back to BREATHE -> level restarts at 0 RISE. With HOLD_STEPS=0 the cycle is 14 steps = 112 clk between cycle_done pulses.
